q2_panel_seq: RTL and testbench
===============================

Q2_PANEL_SEQ -- requirements
Module: q2_panel_seq

Interface
REQ-001 Parameter DEBOUNCE, default 4, meaning: consecutive clk cycles a raw switch level must be stable before its debounced level changes (range 1..15).
REQ-002 Parameter STARVE, default 15, meaning: consecutive cycles a pending panel operation may be blocked by cpu_req before it is forced through (range 1..15).
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sw  input  12  raw front-panel data switches; sampled as deposit data, no debounce.
REQ-006 dep_sw, incp_sw, start_sw, stop_sw  input  1 each  raw front-panel momentary switches, active-high.
REQ-007 halt  input  1  CPU halt condition, level.
REQ-008 p  input  12  current program counter value.
REQ-009 cpu_req  input  1  CPU requests the memory/IO bus this cycle.
REQ-010 cpu_we  input  1  CPU write qualifier, valid with cpu_req.
REQ-011 cpu_addr, cpu_wdata  input  12 each  CPU address and write data.
REQ-012 cpu_gnt  output  1  CPU owns the bus this cycle (combinational).
REQ-013 abus, wdata  output  12 each  muxed bus address and write data.
REQ-014 nwrm  output  1  active-low memory write strobe.
REQ-015 incp  output  1  one-cycle program-counter increment pulse.
REQ-016 run  output  1  CPU run enable, registered.
REQ-017 busy  output  1  high whenever the state is not IDLE or a panel operation is pending.

Function
REQ-018 Each of the four momentary switches SHALL have its own debouncer: a 4-bit counter counts cycles where the raw level differs from the debounced level, and the counter clears when they match; when the count reaches DEBOUNCE, the debounced level takes the raw value and the counter clears.
REQ-019 A rising edge of a debounced level SHALL produce a one-cycle event (dep_ev, incp_ev, start_ev, stop_ev); falling edges produce nothing.
REQ-020 run SHALL be set by start_ev when halt=0 and cleared by stop_ev or by halt=1; stop_ev or halt wins when simultaneous with start_ev.
REQ-021 dep_ev or incp_ev SHALL set a pending register (pend_dep or pend_inc) only when both pending bits are clear and the state is IDLE; otherwise the event is dropped; dep wins when both occur in the same cycle.
REQ-022 The state machine SHALL have states IDLE, DEP_WR, INC.
- IDLE with a pending bit set and cpu_req=0 SHALL go to DEP_WR (pend_dep) or INC (pend_inc) next cycle.
- IDLE with a pending bit set and cpu_req=1 SHALL grant the CPU and increment a wait counter.
- When the wait counter reaches STARVE, the next cycle SHALL go to DEP_WR or INC regardless of cpu_req.
REQ-023 In DEP_WR (1 cycle): abus=p, wdata=sw, nwrm=0, cpu_gnt=0; clear pend_dep; next state INC.
REQ-024 In INC (1 cycle): incp=1, nwrm=1, cpu_gnt=0, abus=p; clear pend_inc; clear the wait counter; next state IDLE.
REQ-025 In IDLE: cpu_gnt=cpu_req; abus=cpu_addr, wdata=cpu_wdata, nwrm=~(cpu_req & cpu_we); incp=0.
REQ-026 Panel operations SHALL be accepted regardless of run; CPU stall is expressed only through cpu_gnt=0.
REQ-027 The wait counter SHALL saturate at STARVE and clear whenever no operation is pending.
REQ-028 Deposit-to-write latency SHALL be 1 cycle from dep_ev when cpu_req=0 (dep_ev cycle N -> DEP_WR in cycle N+1 -> INC in cycle N+2).

Reset
REQ-029 While rst=1 at a clock edge, the block SHALL set:
- state=IDLE; pend_dep=pend_inc=0.
- Debounced levels, debounce counters, edge registers and wait counter = 0.
- run=0.
- Outputs: incp=0, cpu_gnt=0, nwrm=1, abus=0, wdata=0, busy=0 during reset.
REQ-030 rst asserted mid-operation (DEP_WR or INC) SHALL abort it at that edge; no nwrm or incp pulse follows reset.

Verification
REQ-031 Hold start_sw=1 for 3 cycles with DEBOUNCE=4 -> run stays 0. Hold it for 4+ cycles -> run=1 exactly one cycle after the debounced level rises.
REQ-032 run=1, halt=0, cpu_req=0, p=0x010, sw=0xA5C, dep_sw debounced -> next cycle nwrm=0, abus=0x010, wdata=0xA5C; following cycle incp=1; then IDLE, busy=0.
REQ-033 cpu_req held 1 with dep pending, STARVE=15 -> cpu_gnt=1 for 15 cycles, then cpu_gnt=0 with DEP_WR, then INC, then cpu_gnt=1 again.
REQ-034 start_ev and stop_ev in the same cycle -> run=0; start_ev with halt=1 -> run stays 0; halt rising while run=1 -> run=0 next cycle.
REQ-035 dep_ev, then incp_ev while in DEP_WR -> incp_ev dropped; exactly one nwrm pulse and one incp pulse.
REQ-036 rst=1 during DEP_WR -> next cycle state=IDLE, nwrm=1, incp=0, run=0; no incp pulse after rst is released.

Source files
------------

// File: rtl/q2_panel_seq_if.sv
// q2_panel_seq_if -- shared memory/IO bus between the CPU and the front-panel
// sequencer.
//   cpu_req, cpu_we          CPU bus request and write qualifier
//   cpu_addr, cpu_wdata      CPU address and write data (12 bits each)
//   cpu_gnt                  CPU owns the bus this cycle
//   abus, wdata              muxed bus address and write data (12 bits each)
//   nwrm                     active-low memory write strobe
// The sequencer connects through the slave modport.
// The CPU side and the bench connect through the master modport.
interface q2_panel_seq_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [11:0] cpu_wdata;
    logic        cpu_gnt;
    logic [11:0] abus;
    logic [11:0] wdata;
    logic        nwrm;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, abus, wdata, nwrm
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, abus, wdata, nwrm
    );
endinterface

// File: rtl/q2_panel_seq.sv
// q2_panel_seq -- front-panel deposit / increment-PC sequencer with CPU bus
// arbitration.
// The four momentary switches are debounced and converted to rising-edge
// events. The events drive the run flip-flop and a deposit/increment state
// machine. That state machine steals the bus from the CPU.
//   clk, rst                 single clock; synchronous active-high reset
//   bus (slave)              CPU request side and muxed bus outputs
//   sw[11:0]                 deposit data switches (not debounced)
//   dep_sw, incp_sw          raw deposit / increment-PC switches
//   start_sw, stop_sw        raw start / stop switches
//   halt                     CPU halt level
//   p[11:0]                  current program counter
//   incp                     one-cycle PC increment pulse
//   run                      registered CPU run enable
//   busy                     sequencer active or panel operation pending
module q2_panel_seq #(
    parameter int DEBOUNCE = 4,
    parameter int STARVE   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    q2_panel_seq_if.slave        bus,
    input  logic [11:0]          sw,
    input  logic                 dep_sw,
    input  logic                 incp_sw,
    input  logic                 start_sw,
    input  logic                 stop_sw,
    input  logic                 halt,
    input  logic [11:0]          p,
    output logic                 incp,
    output logic                 run,
    output logic                 busy
);

    localparam logic [3:0] DEB_C    = 4'(DEBOUNCE);
    localparam logic [3:0] STARVE_C = 4'(STARVE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DEP_WR = 2'd1,
        INC    = 2'd2
    } state_t;

    // Bit order of the switch vectors: 0 dep, 1 incp, 2 start, 3 stop
    logic [3:0] raw_s;
    logic [3:0] db_r;
    logic [3:0] db_prev_r;
    logic [3:0] cnt_r [4];

    logic dep_ev_s, incp_ev_s, start_ev_s, stop_ev_s;

    state_t     state_r, state_nxt_s;
    logic       pend_dep_r, pend_dep_nxt_s;
    logic       pend_inc_r, pend_inc_nxt_s;
    logic [3:0] wait_r, wait_nxt_s;
    logic       run_r;

    logic        acc_dep_s, acc_inc_s;
    logic        want_dep_s, want_inc_s;
    logic        gnt_s, nwrm_s, incp_s;
    logic [11:0] abus_s, wdata_s;

    assign raw_s = {stop_sw, start_sw, incp_sw, dep_sw};

    // Debouncers: count disagreeing cycles and adopt the raw level once it has been stable for DEBOUNCE cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            db_r      <= 4'b0000;
            db_prev_r <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (raw_s[i] == db_r[i]) begin
                    cnt_r[i] <= 4'd0;
                end else if ((cnt_r[i] + 4'd1) == DEB_C) begin
                    db_r[i]  <= raw_s[i];
                    cnt_r[i] <= 4'd0;
                end else begin
                    cnt_r[i] <= cnt_r[i] + 4'd1;
                end
            end
            db_prev_r <= db_r;
        end
    end

    // Only rising edges of the debounced levels produce events
    assign dep_ev_s   = db_r[0] & ~db_prev_r[0];
    assign incp_ev_s  = db_r[1] & ~db_prev_r[1];
    assign start_ev_s = db_r[2] & ~db_prev_r[2];
    assign stop_ev_s  = db_r[3] & ~db_prev_r[3];

    // Run flip-flop: stop and halt take priority over start
    always_ff @(posedge clk) begin
        if (rst) begin
            run_r <= 1'b0;
        end else if (stop_ev_s || halt) begin
            run_r <= 1'b0;
        end else if (start_ev_s) begin
            run_r <= 1'b1;
        end else begin
            run_r <= run_r;
        end
    end

    // State, pending bits and wait counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            pend_dep_r <= 1'b0;
            pend_inc_r <= 1'b0;
            wait_r     <= 4'd0;
        end else begin
            state_r    <= state_nxt_s;
            pend_dep_r <= pend_dep_nxt_s;
            pend_inc_r <= pend_inc_nxt_s;
            wait_r     <= wait_nxt_s;
        end
    end

    // Next-state and bus mux. An accepted event counts as pending in its own cycle.
    // This lets a deposit with an idle bus reach DEP_WR on the following cycle.
    always_comb begin
        acc_dep_s  = dep_ev_s & (state_r == IDLE) & ~pend_dep_r & ~pend_inc_r;
        acc_inc_s  = incp_ev_s & ~dep_ev_s & (state_r == IDLE) & ~pend_dep_r & ~pend_inc_r;
        want_dep_s = pend_dep_r | acc_dep_s;
        want_inc_s = pend_inc_r | acc_inc_s;

        state_nxt_s    = state_r;
        pend_dep_nxt_s = pend_dep_r;
        pend_inc_nxt_s = pend_inc_r;
        wait_nxt_s     = wait_r;
        gnt_s          = 1'b0;
        nwrm_s         = 1'b1;
        incp_s         = 1'b0;
        abus_s         = 12'h000;
        wdata_s        = 12'h000;

        case (state_r)
            IDLE: begin
                gnt_s          = bus.cpu_req;
                abus_s         = bus.cpu_addr;
                wdata_s        = bus.cpu_wdata;
                nwrm_s         = ~(bus.cpu_req & bus.cpu_we);
                pend_dep_nxt_s = want_dep_s;
                pend_inc_nxt_s = want_inc_s;
                if (want_dep_s || want_inc_s) begin
                    if (!bus.cpu_req || (wait_r == STARVE_C)) begin
                        state_nxt_s = want_dep_s ? DEP_WR : INC;
                    end else begin
                        // Reaching STARVE forces the transition above, so this cannot pass STARVE
                        wait_nxt_s = wait_r + 4'd1;
                    end
                end else begin
                    wait_nxt_s = 4'd0;
                end
            end
            DEP_WR: begin
                abus_s         = p;
                wdata_s        = sw;
                nwrm_s         = 1'b0;
                pend_dep_nxt_s = 1'b0;
                state_nxt_s    = INC;
            end
            INC: begin
                abus_s         = p;
                wdata_s        = sw;
                incp_s         = 1'b1;
                pend_inc_nxt_s = 1'b0;
                wait_nxt_s     = 4'd0;
                state_nxt_s    = IDLE;
            end
            default: begin
                pend_dep_nxt_s = 1'b0;
                pend_inc_nxt_s = 1'b0;
                wait_nxt_s     = 4'd0;
                state_nxt_s    = IDLE;
            end
        endcase
    end

    // While rst is high the bus reads as idle, whatever the current state
    assign bus.cpu_gnt = rst ? 1'b0    : gnt_s;
    assign bus.abus    = rst ? 12'h000 : abus_s;
    assign bus.wdata   = rst ? 12'h000 : wdata_s;
    assign bus.nwrm    = rst ? 1'b1    : nwrm_s;
    assign incp        = rst ? 1'b0    : incp_s;
    assign busy        = rst ? 1'b0    : ((state_r != IDLE) | pend_dep_r | pend_inc_r);
    assign run         = run_r;

endmodule

// File: tb/tb_q2_panel_seq.sv
// Directed bench for q2_panel_seq (DEBOUNCE=4, STARVE=15).
// Inputs change 1 time unit after each rising edge. Outputs are checked 2 units after the edge.
module tb_q2_panel_seq;
    logic        clk;
    logic        rst;
    logic [11:0] sw;
    logic        dep_sw, incp_sw, start_sw, stop_sw;
    logic        halt;
    logic [11:0] p;
    logic        incp, run, busy;
    int          checks;
    int          errors;

    q2_panel_seq_if bus ();

    q2_panel_seq #(.DEBOUNCE(4), .STARVE(15)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .sw       (sw),
        .dep_sw   (dep_sw),
        .incp_sw  (incp_sw),
        .start_sw (start_sw),
        .stop_sw  (stop_sw),
        .halt     (halt),
        .p        (p),
        .incp     (incp),
        .run      (run),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; sw = 12'hFFF; dep_sw = 1'b0; incp_sw = 1'b0; start_sw = 1'b0; stop_sw = 1'b0;
        halt = 1'b0; p = 12'hFFF;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 12'hFFF; bus.cpu_wdata = 12'hFFF;
        tick(); tick(); settle();
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL reset_run got %0b want 0", run); end
        checks++; if (bus.cpu_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got %0b want 0", bus.cpu_gnt); end
        checks++; if (bus.nwrm !== 1'b1) begin errors++; $display("FAIL reset_nwrm got %0b want 1", bus.nwrm); end
        checks++; if (bus.abus !== 12'h000) begin errors++; $display("FAIL reset_abus got %h want 000", bus.abus); end
        checks++; if (bus.wdata !== 12'h000) begin errors++; $display("FAIL reset_wdata got %h want 000", bus.wdata); end
        checks++; if (incp !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_incp_busy got %0b%0b want 00", incp, busy); end
        rst = 1'b0; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h123; bus.cpu_wdata = 12'h456;
        tick();
    endtask

    task automatic test_debounce_start();
        start_sw = 1'b1;
        repeat (3) tick();
        start_sw = 1'b0;
        repeat (3) tick(); settle();
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL short_press_run got %0b want 0", run); end
        start_sw = 1'b1;
        repeat (4) tick(); settle();
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL run_before_edge got %0b want 0", run); end
        tick(); settle();
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL run_after_start got %0b want 1", run); end
        start_sw = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_deposit();
        p = 12'h010; sw = 12'hA5C;
        dep_sw = 1'b1;
        repeat (4) tick(); settle();
        checks++; if (busy !== 1'b0 || bus.abus !== 12'h123) begin errors++; $display("FAIL dep_ev_cycle got busy=%0b abus=%h want busy=0 abus=123", busy, bus.abus); end
        tick(); dep_sw = 1'b0; settle();
        checks++; if (bus.nwrm !== 1'b0) begin errors++; $display("FAIL dep_nwrm got %0b want 0", bus.nwrm); end
        checks++; if (bus.abus !== 12'h010) begin errors++; $display("FAIL dep_abus got %h want 010", bus.abus); end
        checks++; if (bus.wdata !== 12'hA5C) begin errors++; $display("FAIL dep_wdata got %h want a5c", bus.wdata); end
        checks++; if (bus.cpu_gnt !== 1'b0 || incp !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL dep_ctl got gnt=%0b incp=%0b busy=%0b want 0 0 1", bus.cpu_gnt, incp, busy); end
        tick(); settle();
        checks++; if (incp !== 1'b1 || bus.nwrm !== 1'b1 || bus.abus !== 12'h010) begin errors++; $display("FAIL inc_cycle got incp=%0b nwrm=%0b abus=%h want 1 1 010", incp, bus.nwrm, bus.abus); end
        tick(); settle();
        checks++; if (incp !== 1'b0 || busy !== 1'b0 || bus.abus !== 12'h123) begin errors++; $display("FAIL dep_done got incp=%0b busy=%0b abus=%h want 0 0 123", incp, busy, bus.abus); end
        repeat (6) tick(); settle();
        checks++; if (busy !== 1'b0 || incp !== 1'b0) begin errors++; $display("FAIL dep_release got busy=%0b incp=%0b want 0 0", busy, incp); end
    endtask

    task automatic test_starve();
        int gnt_cnt;
        p = 12'h077; sw = 12'h0F0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 12'h321; bus.cpu_wdata = 12'h654;
        dep_sw = 1'b1;
        repeat (4) tick(); settle();
        checks++; if (bus.cpu_gnt !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL starve_ev got gnt=%0b busy=%0b want 1 0", bus.cpu_gnt, busy); end
        dep_sw = 1'b0;
        gnt_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick(); settle();
            if (busy === 1'b1 && bus.cpu_gnt === 1'b1) gnt_cnt++;
            else break;
        end
        checks++; if (gnt_cnt !== 15) begin errors++; $display("FAIL starve_grants got %0d want 15", gnt_cnt); end
        checks++; if (bus.cpu_gnt !== 1'b0 || bus.nwrm !== 1'b0 || bus.abus !== 12'h077 || bus.wdata !== 12'h0F0) begin
            errors++; $display("FAIL starve_depwr got gnt=%0b nwrm=%0b abus=%h wdata=%h want 0 0 077 0f0", bus.cpu_gnt, bus.nwrm, bus.abus, bus.wdata); end
        tick(); settle();
        checks++; if (incp !== 1'b1 || bus.cpu_gnt !== 1'b0) begin errors++; $display("FAIL starve_inc got incp=%0b gnt=%0b want 1 0", incp, bus.cpu_gnt); end
        tick(); settle();
        checks++; if (bus.cpu_gnt !== 1'b1 || busy !== 1'b0 || bus.abus !== 12'h321 || bus.nwrm !== 1'b0) begin
            errors++; $display("FAIL starve_regrant got gnt=%0b busy=%0b abus=%h nwrm=%0b want 1 0 321 0", bus.cpu_gnt, busy, bus.abus, bus.nwrm); end
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h123;
        repeat (6) tick();
    endtask

    task automatic test_run_ctrl();
        settle();
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL run_held got %0b want 1", run); end
        halt = 1'b1;
        tick(); settle();
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL halt_clears_run got %0b want 0", run); end
        halt = 1'b0;
        start_sw = 1'b1; stop_sw = 1'b1;
        repeat (5) tick(); settle();
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL start_stop_same got %0b want 0", run); end
        start_sw = 1'b0; stop_sw = 1'b0;
        repeat (6) tick();
        halt = 1'b1; start_sw = 1'b1;
        repeat (5) tick(); settle();
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL start_in_halt got %0b want 0", run); end
        start_sw = 1'b0;
        repeat (6) tick();
        halt = 1'b0; start_sw = 1'b1;
        repeat (5) tick(); settle();
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL restart got %0b want 1", run); end
        start_sw = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_drop();
        int wr_cnt;
        int inc_cnt;
        wr_cnt = 0; inc_cnt = 0;
        dep_sw = 1'b1;
        tick();
        incp_sw = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick(); settle();
            if (bus.nwrm === 1'b0) wr_cnt++;
            if (incp === 1'b1) inc_cnt++;
        end
        checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL drop_writes got %0d want 1", wr_cnt); end
        checks++; if (inc_cnt !== 1) begin errors++; $display("FAIL drop_incs got %0d want 1", inc_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy got %0b want 0", busy); end
        dep_sw = 1'b0; incp_sw = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_reset_mid();
        int inc_cnt;
        int wr_cnt;
        dep_sw = 1'b1;
        repeat (5) tick(); settle();
        checks++; if (bus.nwrm !== 1'b0) begin errors++; $display("FAIL mid_depwr got nwrm=%0b want 0", bus.nwrm); end
        rst = 1'b1; dep_sw = 1'b0;
        tick(); settle();
        checks++; if (bus.nwrm !== 1'b1 || incp !== 1'b0 || run !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset got nwrm=%0b incp=%0b run=%0b busy=%0b want 1 0 0 0", bus.nwrm, incp, run, busy); end
        rst = 1'b0;
        inc_cnt = 0; wr_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick(); settle();
            if (incp === 1'b1) inc_cnt++;
            if (bus.nwrm === 1'b0) wr_cnt++;
        end
        checks++; if (inc_cnt !== 0 || wr_cnt !== 0) begin errors++; $display("FAIL post_reset_pulses got incp=%0d nwrm=%0d want 0 0", inc_cnt, wr_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %0b want 0", busy); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_debounce_start();
        test_deposit();
        test_starve();
        test_run_ctrl();
        test_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
